// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (core / host) arbiter in front of a fixed-latency
// data memory. One transaction at a time: IDLE -> ACCESS (LAT cycles) -> RESP.
// Ties in IDLE are broken round-robin, so a waiting port is always served next.
// All memory drive and done outputs are registered.
module mem_arbiter #(
   parameter int AW  = 8,
   parameter int DW  = 8,
   parameter int LAT = 2
) (
   input  logic          CLK,
   input  logic          reset_n,
   // core port
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic [DW-1:0] core_rdata,
   output logic          core_done,
   output logic          core_stall,
   // host / test-loader port
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic [DW-1:0] host_rdata,
   output logic          host_done,
   // data memory drive
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   // status
   output logic          busy
);

   // A latency below one cycle is meaningless for a registered memory; clamp it.
   localparam int LAT_E = (LAT < 1) ? 1 : LAT;
   localparam int CW    = (LAT_E > 1) ? $clog2(LAT_E) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(LAT_E - 1);

   // Port indices used for owner / last_grant bookkeeping.
   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_HOST = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t          state_reg;
   logic [CW-1:0]   cnt_reg;
   logic            last_grant_reg;
   logic            owner_reg;
   logic            we_lat_reg;
   logic [1:0]      done_reg;
   logic            mem_en_reg;
   logic            mem_we_reg;
   logic [AW-1:0]   mem_addr_reg;
   logic [DW-1:0]   mem_wdata_reg;

   // Requester inputs gathered into port-indexed vectors (0 = core, 1 = host)
   logic [1:0]      req_vec;
   logic [1:0]      we_vec;
   logic [AW-1:0]   addr_arr  [2];
   logic [DW-1:0]   wdata_arr [2];

   logic            grant_valid;
   logic            grant_next;
   logic            last_access;

   assign req_vec      = {host_req, core_req};
   assign we_vec       = {host_we,  core_we};
   assign addr_arr[0]  = core_addr;
   assign addr_arr[1]  = host_addr;
   assign wdata_arr[0] = core_wdata;
   assign wdata_arr[1] = host_wdata;

   // Round-robin grant: a tie goes to the port that did not win last time.
   always_comb begin
      grant_valid = |req_vec;
      grant_next  = PORT_CORE;
      if (req_vec == 2'b11) begin
         grant_next = ~last_grant_reg;
      end else if (req_vec[1]) begin
         grant_next = PORT_HOST;
      end
   end

   // The edge that closes the final ACCESS cycle; read data is valid here.
   assign last_access = (state_reg == ACCESS) && (cnt_reg == '0);

   // Transaction FSM; owner/we/addr/wdata are latched at grant and held, so
   // requester activity during ACCESS/RESP has no effect.
   always_ff @(posedge CLK) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         last_grant_reg <= PORT_HOST;
         owner_reg      <= PORT_CORE;
         we_lat_reg     <= 1'b0;
         done_reg       <= 2'b00;
         mem_en_reg     <= 1'b0;
         mem_we_reg     <= 1'b0;
         mem_addr_reg   <= '0;
         mem_wdata_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 2'b00;
               if (grant_valid) begin
                  state_reg      <= ACCESS;
                  cnt_reg        <= CNT_LOAD;
                  owner_reg      <= grant_next;
                  last_grant_reg <= grant_next;
                  we_lat_reg     <= we_vec[grant_next];
                  mem_en_reg     <= 1'b1;
                  // Write strobe covers only the first ACCESS cycle.
                  mem_we_reg     <= we_vec[grant_next];
                  mem_addr_reg   <= addr_arr[grant_next];
                  mem_wdata_reg  <= wdata_arr[grant_next];
               end
            end
            ACCESS: begin
               mem_we_reg <= 1'b0;
               if (cnt_reg == '0) begin
                  state_reg     <= RESP;
                  mem_en_reg    <= 1'b0;
                  mem_addr_reg  <= '0;
                  mem_wdata_reg <= '0;
                  done_reg      <= (owner_reg == PORT_HOST) ? 2'b10 : 2'b01;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            RESP: begin
               done_reg  <= 2'b00;
               state_reg <= IDLE;
            end
            default: begin
               state_reg  <= IDLE;
               done_reg   <= 2'b00;
               mem_en_reg <= 1'b0;
               mem_we_reg <= 1'b0;
            end
         endcase
      end
   end

   // Per-port read-data holding registers.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         logic [DW-1:0] rdata_reg;

         // Capture memory data on the last ACCESS edge of this port's own read.
         always_ff @(posedge CLK) begin
            if (!reset_n) begin
               rdata_reg <= '0;
            end else if (last_access && !we_lat_reg && (owner_reg == 1'(gi))) begin
               rdata_reg <= mem_rdata;
            end
         end
      end
   endgenerate

   assign core_rdata = g_port[0].rdata_reg;
   assign host_rdata = g_port[1].rdata_reg;
   assign core_done  = done_reg[0];
   assign host_done  = done_reg[1];
   assign core_stall = core_req & ~core_done;

   assign mem_en     = mem_en_reg;
   assign mem_we     = mem_we_reg;
   assign mem_addr   = mem_addr_reg;
   assign mem_wdata  = mem_wdata_reg;
   assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario tests for mem_arbiter. One LAT=2 instance
// carries most scenarios; three more instances cover LAT=1, LAT=4 and LAT=0.
// Inputs are driven and outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int AW = 8;
   localparam int DW = 8;

   logic          clk;
   logic          reset_n;

   logic          core_req, core_we;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wdata;
   logic [DW-1:0] core_rdata;
   logic          core_done, core_stall;
   logic          host_req, host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic [DW-1:0] host_rdata;
   logic          host_done;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          busy;

   // auxiliary instances: index 0 -> LAT=1, 1 -> LAT=4, 2 -> LAT=0
   logic          a_req    [3];
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_rdata  [3];
   logic          a_done   [3];
   logic          a_stall  [3];
   logic [DW-1:0] a_hrdata [3];
   logic          a_hdone  [3];
   logic          a_en     [3];
   logic          a_we     [3];
   logic [AW-1:0] a_maddr  [3];
   logic [DW-1:0] a_mwdata [3];
   logic [DW-1:0] a_mrdata [3];
   logic          a_busy   [3];

   int checks;
   int failures;

   // data memory model: preloaded on the first edge, written by the main DUT
   logic [DW-1:0] mem [256];
   logic          mem_init_done = 1'b0;

   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
         mem[8'h10]    <= 8'hA5;
         mem[8'h30]    <= 8'h5A;
         mem[8'h40]    <= 8'hC3;
         mem_init_done <= 1'b1;
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   assign mem_rdata = mem[mem_addr];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   mem_arbiter #(.AW(AW), .DW(DW), .LAT(2)) dut (
      .CLK(clk), .reset_n(reset_n),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_rdata(core_rdata), .core_done(core_done), .core_stall(core_stall),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_rdata(host_rdata), .host_done(host_done),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_aux
         assign a_mrdata[gi] = mem[a_maddr[gi]];
         mem_arbiter #(.AW(AW), .DW(DW), .LAT(gi == 0 ? 1 : (gi == 1 ? 4 : 0))) aux (
            .CLK(clk), .reset_n(reset_n),
            .core_req(a_req[gi]), .core_we(1'b0), .core_addr(a_addr), .core_wdata(8'h00),
            .core_rdata(a_rdata[gi]), .core_done(a_done[gi]), .core_stall(a_stall[gi]),
            .host_req(1'b0), .host_we(1'b0), .host_addr(8'h00), .host_wdata(8'h00),
            .host_rdata(a_hrdata[gi]), .host_done(a_hdone[gi]),
            .mem_en(a_en[gi]), .mem_we(a_we[gi]), .mem_addr(a_maddr[gi]), .mem_wdata(a_mwdata[gi]),
            .mem_rdata(a_mrdata[gi]), .busy(a_busy[gi])
         );
      end
   endgenerate

   task automatic test_reset();
      reset_n = 1'b0;
      core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
      host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
      a_addr = '0;
      for (int i = 0; i < 3; i++) a_req[i] = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
      checks++; if (core_done !== 1'b0 || host_done !== 1'b0) begin failures++; $display("FAIL reset_done: got core=%0b host=%0b want 0/0", core_done, host_done); end
      checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem: got en=%0b we=%0b want 0/0", mem_en, mem_we); end
      checks++; if (core_rdata !== 8'h00 || host_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata: got core=%0h host=%0h want 0/0", core_rdata, host_rdata); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (a_busy[i] !== 1'b0 || a_done[i] !== 1'b0) begin failures++; $display("FAIL reset_aux%0d: got busy=%0b done=%0b want 0/0", i, a_busy[i], a_done[i]); end
      end
      reset_n = 1'b1;
      @(negedge clk);
      $display("test_reset done checks=%0d", checks);
   endtask

   // core read of 0x10 (0xA5), LAT=2: mem_en cycles 1-2, done cycle 3
   task automatic test_core_read();
      logic          exp_en, exp_done;
      logic [AW-1:0] exp_addr;
      @(negedge clk);
      core_req = 1'b1; core_we = 1'b0; core_addr = 8'h10; core_wdata = 8'h00;
      #1;
      checks++; if (core_stall !== 1'b1) begin failures++; $display("FAIL rd_stall c0: got %0b want 1", core_stall); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rd_busy c0: got %0b want 0", busy); end
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         exp_en   = (c <= 2);
         exp_done = (c == 3);
         exp_addr = exp_en ? 8'h10 : 8'h00;
         checks++; if (mem_en !== exp_en) begin failures++; $display("FAIL rd_mem_en c%0d: got %0b want %0b", c, mem_en, exp_en); end
         checks++; if (mem_addr !== exp_addr) begin failures++; $display("FAIL rd_mem_addr c%0d: got %0h want %0h", c, mem_addr, exp_addr); end
         checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rd_mem_we c%0d: got %0b want 0", c, mem_we); end
         checks++; if (core_done !== exp_done) begin failures++; $display("FAIL rd_done c%0d: got %0b want %0b", c, core_done, exp_done); end
         checks++; if (core_stall !== !exp_done) begin failures++; $display("FAIL rd_stall c%0d: got %0b want %0b", c, core_stall, !exp_done); end
         checks++; if (busy !== 1'b1 || host_done !== 1'b0) begin failures++; $display("FAIL rd_busy c%0d: got busy=%0b host_done=%0b want 1/0", c, busy, host_done); end
      end
      checks++; if (core_rdata !== 8'hA5) begin failures++; $display("FAIL rd_rdata: got %0h want a5", core_rdata); end
      core_req = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || core_done !== 1'b0) begin failures++; $display("FAIL rd_idle: got busy=%0b done=%0b want 0/0", busy, core_done); end
      $display("test_core_read done rdata=%0h", core_rdata);
   endtask

   // core write 0x3C to 0x20; inputs scrambled during ACCESS must be ignored
   task automatic test_core_write();
      logic          exp_en, exp_we, exp_done;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_wd;
      @(negedge clk);
      core_req = 1'b1; core_we = 1'b1; core_addr = 8'h20; core_wdata = 8'h3C;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         exp_en   = (c <= 2);
         exp_we   = (c == 1);
         exp_done = (c == 3);
         exp_addr = exp_en ? 8'h20 : 8'h00;
         exp_wd   = exp_en ? 8'h3C : 8'h00;
         checks++; if (mem_we !== exp_we) begin failures++; $display("FAIL wr_mem_we c%0d: got %0b want %0b", c, mem_we, exp_we); end
         checks++; if (mem_en !== exp_en) begin failures++; $display("FAIL wr_mem_en c%0d: got %0b want %0b", c, mem_en, exp_en); end
         checks++; if (mem_addr !== exp_addr) begin failures++; $display("FAIL wr_mem_addr c%0d: got %0h want %0h", c, mem_addr, exp_addr); end
         checks++; if (mem_wdata !== exp_wd) begin failures++; $display("FAIL wr_mem_wdata c%0d: got %0h want %0h", c, mem_wdata, exp_wd); end
         checks++; if (core_done !== exp_done) begin failures++; $display("FAIL wr_done c%0d: got %0b want %0b", c, core_done, exp_done); end
         if (c == 1) begin
            core_addr = 8'hEE; core_wdata = 8'h11; core_we = 1'b0;
         end
      end
      checks++; if (core_rdata !== 8'hA5) begin failures++; $display("FAIL wr_rdata_kept: got %0h want a5", core_rdata); end
      core_req = 1'b0; core_we = 1'b0;
      @(negedge clk);
      checks++; if (mem[8'h20] !== 8'h3C) begin failures++; $display("FAIL wr_mem_content: got %0h want 3c", mem[8'h20]); end
      $display("test_core_write done mem[20]=%0h", mem[8'h20]);
   endtask

   // first tie after reset: core wins (done c3), host next (done c7)
   task automatic test_tie_first();
      logic          exp_cd, exp_hd, exp_busy, exp_stall;
      logic [AW-1:0] exp_addr;
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      core_req = 1'b1; core_we = 1'b0; core_addr = 8'h10;
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h30;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         exp_cd    = (c == 3);
         exp_hd    = (c == 7);
         exp_busy  = (c != 4);
         exp_stall = (c <= 2);
         exp_addr  = (c == 1 || c == 2) ? 8'h10 : ((c == 5 || c == 6) ? 8'h30 : 8'h00);
         checks++; if (core_done !== exp_cd) begin failures++; $display("FAIL tie1_core_done c%0d: got %0b want %0b", c, core_done, exp_cd); end
         checks++; if (host_done !== exp_hd) begin failures++; $display("FAIL tie1_host_done c%0d: got %0b want %0b", c, host_done, exp_hd); end
         checks++; if (mem_addr !== exp_addr) begin failures++; $display("FAIL tie1_mem_addr c%0d: got %0h want %0h", c, mem_addr, exp_addr); end
         checks++; if (busy !== exp_busy) begin failures++; $display("FAIL tie1_busy c%0d: got %0b want %0b", c, busy, exp_busy); end
         checks++; if (core_stall !== exp_stall) begin failures++; $display("FAIL tie1_stall c%0d: got %0b want %0b", c, core_stall, exp_stall); end
         if (c == 3) begin
            checks++; if (core_rdata !== 8'hA5) begin failures++; $display("FAIL tie1_core_rdata: got %0h want a5", core_rdata); end
            core_req = 1'b0;
         end
         if (c == 7) begin
            checks++; if (host_rdata !== 8'h5A) begin failures++; $display("FAIL tie1_host_rdata: got %0h want 5a", host_rdata); end
            host_req = 1'b0;
         end
      end
      $display("test_tie_first done core=%0h host=%0h", core_rdata, host_rdata);
   endtask

   // second tie -> core; core re-requests, third tie -> host; then core again.
   // Throughput: one completion every LAT+2 = 4 cycles.
   task automatic test_back_to_back();
      logic          exp_cd, exp_hd, exp_busy, exp_stall, exp_en;
      logic [AW-1:0] exp_addr;
      @(negedge clk);
      core_req = 1'b1; core_we = 1'b0; core_addr = 8'h40;
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         exp_cd    = (c == 3 || c == 11);
         exp_hd    = (c == 7);
         exp_busy  = (c != 4 && c != 8);
         exp_stall = !exp_cd;
         exp_en    = (c == 1 || c == 2 || c == 5 || c == 6 || c == 9 || c == 10);
         exp_addr  = (c == 5 || c == 6) ? 8'h10 : (exp_en ? 8'h40 : 8'h00);
         checks++; if (core_done !== exp_cd) begin failures++; $display("FAIL b2b_core_done c%0d: got %0b want %0b", c, core_done, exp_cd); end
         checks++; if (host_done !== exp_hd) begin failures++; $display("FAIL b2b_host_done c%0d: got %0b want %0b", c, host_done, exp_hd); end
         checks++; if (mem_en !== exp_en) begin failures++; $display("FAIL b2b_mem_en c%0d: got %0b want %0b", c, mem_en, exp_en); end
         checks++; if (mem_addr !== exp_addr) begin failures++; $display("FAIL b2b_mem_addr c%0d: got %0h want %0h", c, mem_addr, exp_addr); end
         checks++; if (busy !== exp_busy) begin failures++; $display("FAIL b2b_busy c%0d: got %0b want %0b", c, busy, exp_busy); end
         checks++; if (core_stall !== exp_stall) begin failures++; $display("FAIL b2b_stall c%0d: got %0b want %0b", c, core_stall, exp_stall); end
         if (c == 3) begin
            checks++; if (core_rdata !== 8'hC3) begin failures++; $display("FAIL b2b_core_rdata1: got %0h want c3", core_rdata); end
         end
         if (c == 7) begin
            checks++; if (host_rdata !== 8'hA5) begin failures++; $display("FAIL b2b_host_rdata: got %0h want a5", host_rdata); end
            host_req = 1'b0;
         end
         if (c == 11) begin
            checks++; if (core_rdata !== 8'hC3) begin failures++; $display("FAIL b2b_core_rdata2: got %0h want c3", core_rdata); end
            core_req = 1'b0;
         end
      end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle: got busy=%0b want 0", busy); end
      $display("test_back_to_back done host_rdata=%0h", host_rdata);
   endtask

   // reset during cycle 2 of a host read: no done, rdata cleared, reset beats req
   task automatic test_reset_mid_access();
      @(negedge clk);
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h30;
      #1;
      checks++; if (host_rdata !== 8'hA5) begin failures++; $display("FAIL rst_hold_rdata c0: got %0h want a5", host_rdata); end
      @(negedge clk);
      checks++; if (mem_en !== 1'b1 || mem_addr !== 8'h30) begin failures++; $display("FAIL rst_access c1: got en=%0b addr=%0h want 1/30", mem_en, mem_addr); end
      @(negedge clk);
      checks++; if (mem_en !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL rst_access c2: got en=%0b busy=%0b want 1/1", mem_en, busy); end
      reset_n = 1'b0;
      @(negedge clk);
      checks++; if (host_done !== 1'b0) begin failures++; $display("FAIL rst_host_done c3: got %0b want 0", host_done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy c3: got %0b want 0", busy); end
      checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem c3: got en=%0b we=%0b want 0/0", mem_en, mem_we); end
      checks++; if (host_rdata !== 8'h00 || core_rdata !== 8'h00) begin failures++; $display("FAIL rst_rdata c3: got host=%0h core=%0h want 0/0", host_rdata, core_rdata); end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || host_done !== 1'b0) begin failures++; $display("FAIL rst_dominates c4: got busy=%0b done=%0b want 0/0", busy, host_done); end
      reset_n = 1'b1; host_req = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || host_done !== 1'b0) begin failures++; $display("FAIL rst_after c5: got busy=%0b done=%0b want 0/0", busy, host_done); end
      $display("test_reset_mid_access done host_rdata=%0h", host_rdata);
   endtask

   // LAT=1 -> done c2, LAT=4 -> done c5, LAT=0 -> same as LAT=1
   task automatic test_lat_variants();
      int   done_cyc [3];
      logic exp_done, exp_en;
      done_cyc = '{2, 5, 2};
      @(negedge clk);
      a_addr = 8'h40;
      for (int i = 0; i < 3; i++) a_req[i] = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            exp_done = (c == done_cyc[i]);
            exp_en   = (c < done_cyc[i]);
            checks++; if (a_done[i] !== exp_done) begin failures++; $display("FAIL lat_done aux%0d c%0d: got %0b want %0b", i, c, a_done[i], exp_done); end
            checks++; if (a_en[i] !== exp_en) begin failures++; $display("FAIL lat_mem_en aux%0d c%0d: got %0b want %0b", i, c, a_en[i], exp_en); end
            if (exp_done) begin
               checks++; if (a_rdata[i] !== 8'hC3) begin failures++; $display("FAIL lat_rdata aux%0d: got %0h want c3", i, a_rdata[i]); end
               a_req[i] = 1'b0;
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (a_busy[i] !== 1'b0 || a_stall[i] !== 1'b0 || a_we[i] !== 1'b0 || a_hdone[i] !== 1'b0 ||
             a_hrdata[i] !== 8'h00 || a_mwdata[i] !== 8'h00) begin
            failures++;
            $display("FAIL lat_quiet aux%0d: got busy=%0b stall=%0b we=%0b hdone=%0b hrdata=%0h wdata=%0h want all 0",
                     i, a_busy[i], a_stall[i], a_we[i], a_hdone[i], a_hrdata[i], a_mwdata[i]);
         end
      end
      $display("test_lat_variants done");
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_core_read();
      test_core_write();
      test_tie_first();
      test_back_to_back();
      test_reset_mid_access();
      test_lat_variants();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
